rv32i_mem_arbiter: RTL

//  Shares one single-port memory between the rv32i instruction-fetch port and the load/store data port.

---
 rtl/rv32i_mem_arbiter_if.sv | 57 +++++
 rtl/rv32i_mem_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/rv32i_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_mem_arbiter_if
//  Brief    : Request/response bundle between the rv32i fetch port, the
//             load/store port, the shared memory and the arbiter.
//             slave  = arbiter side, master = requester/memory side.
//  Revision : 1.0  initial release
// ============================================================================
interface rv32i_mem_arbiter_if #(
  parameter int XLEN = 32
);
  // instruction fetch port
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic            if_gnt;
  logic            if_rvalid;
  logic [XLEN-1:0] if_rdata;
  logic            if_err;
  // load/store port
  logic            d_req;
  logic            d_we;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic [3:0]      d_be;
  logic            d_gnt;
  logic            d_rvalid;
  logic [XLEN-1:0] d_rdata;
  logic            d_err;
  // shared memory port
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_be;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata, if_err,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/rv32i_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_mem_arbiter
//  Brief    : Shares one single-port memory between the rv32i fetch port and
//             the load/store port. One transaction in flight; a watchdog
//             turns a lost memory response into an error response.
//  Options  : MEM_ARB_RR_EN - round-robin tie-break (default: data port wins)
//  Revision : 1.0  initial release
// ============================================================================
module rv32i_mem_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  rv32i_mem_arbiter_if.slave  bus
);

  localparam int              TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]   TIMER_ONE  = TW'(1);
  localparam logic            OWNER_FETCH = 1'b0;
  localparam logic            OWNER_DATA  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TW-1:0]   r_timer;
  logic            r_owner;
  logic            r_mem_we;
  logic [XLEN-1:0] r_mem_addr;
  logic [XLEN-1:0] r_mem_wdata;
  logic [3:0]      r_mem_be;
  logic            r_if_rvalid;
  logic            r_if_err;
  logic [XLEN-1:0] r_if_rdata;
  logic            r_d_rvalid;
  logic            r_d_err;
  logic [XLEN-1:0] r_d_rdata;

  logic            w_take;
  logic            w_pick_data;
  logic            w_data_wins_tie;
  logic            w_mem_req;
  logic            w_rsp_fire;
  logic            w_timeout;

`ifdef MEM_ARB_RR_EN
  logic            r_last_grant;

  // remember who was served last so a tie goes to the other port
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    r_last_grant <= OWNER_FETCH;
    else if (w_take) r_last_grant <= w_pick_data;
  end

  assign w_data_wins_tie = (r_last_grant == OWNER_FETCH);
`else
  assign w_data_wins_tie = 1'b1;
`endif

  // state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // next state, arbitration and response decision
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_pick_data = 1'b0;
    w_mem_req   = 1'b0;
    w_rsp_fire  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.if_req || bus.d_req) begin
          w_take      = 1'b1;
          w_pick_data = bus.d_req && (!bus.if_req || w_data_wins_tie);
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_mem_req = 1'b1;
        if (bus.mem_gnt) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // a response arriving on the last allowed cycle still counts as good
        w_timeout = !bus.mem_rvalid && (r_timer == TIMER_LAST);
        if (bus.mem_rvalid || w_timeout) begin
          w_rsp_fire  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // capture the winner's request fields; they stay put until the next grant
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_owner     <= OWNER_FETCH;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= 4'b0000;
    end else if (w_take) begin
      r_owner <= w_pick_data;
      if (w_pick_data) begin
        r_mem_we    <= bus.d_we;
        r_mem_addr  <= bus.d_addr;
        r_mem_wdata <= bus.d_wdata;
        r_mem_be    <= bus.d_be;
      end else begin
        r_mem_we    <= 1'b0;
        r_mem_addr  <= bus.if_addr;
        r_mem_wdata <= '0;
        r_mem_be    <= 4'b1111;
      end
    end
  end

  // watchdog: counts WAIT cycles without a response, cleared on issue
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                r_timer <= '0;
    else if (r_state == ST_ISSUE && bus.mem_gnt) r_timer <= '0;
    else if (r_state == ST_WAIT && !w_rsp_fire)  r_timer <= r_timer + TIMER_ONE;
  end

  // route the response to the owner; valid/err pulse, rdata holds
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_if_rvalid <= 1'b0;
      r_if_err    <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rvalid  <= 1'b0;
      r_d_err     <= 1'b0;
      r_d_rdata   <= '0;
    end else begin
      r_if_rvalid <= w_rsp_fire && (r_owner == OWNER_FETCH);
      r_d_rvalid  <= w_rsp_fire && (r_owner == OWNER_DATA);
      r_if_err    <= w_rsp_fire && w_timeout && (r_owner == OWNER_FETCH);
      r_d_err     <= w_rsp_fire && w_timeout && (r_owner == OWNER_DATA);
      if (w_rsp_fire && (r_owner == OWNER_FETCH)) r_if_rdata <= w_timeout ? '0 : bus.mem_rdata;
      if (w_rsp_fire && (r_owner == OWNER_DATA))  r_d_rdata  <= w_timeout ? '0 : bus.mem_rdata;
    end
  end

  assign bus.if_gnt    = w_take && !w_pick_data;
  assign bus.d_gnt     = w_take && w_pick_data;
  assign bus.mem_req   = w_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_be    = r_mem_be;
  assign bus.if_rvalid = r_if_rvalid;
  assign bus.if_err    = r_if_err;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_rvalid  = r_d_rvalid;
  assign bus.d_err     = r_d_err;
  assign bus.d_rdata   = r_d_rdata;

endmodule
`default_nettype wire
